// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock: code geometry, reset code and
// the programming FSM encoding, used by both writer and reader.
package lock_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int CODE_W     = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_CHECK  = 2'd3
  } prog_state_e;

  // Replace slot idx of a code word; digit 0 lives in the MSBs.
  function automatic logic [CODE_W-1:0] set_digit(input logic [CODE_W-1:0] b,
                                                  input logic [IDX_W-1:0]  idx,
                                                  input logic [DIGIT_W-1:0] d);
    logic [CODE_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IDX_W'(i)) r[CODE_W-1-i*DIGIT_W -: DIGIT_W] = d;
    return r;
  endfunction
endpackage

// File: rtl/lock_code_writer_digit_entry.sv
// Digit editor: current digit value and slot index, with increment, accept
// (advance to next slot) and clear; flags when the last slot is selected.
module digit_entry
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               accept,
  input  logic               clr,
  output logic [DIGIT_W-1:0] cur_digit,
  output logic [IDX_W-1:0]   digit_idx,
  output logic               last_digit
);
  logic [DIGIT_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  assign last_digit = (idx_q == IDX_W'(NUM_DIGITS-1));

  always_comb begin
    cur_d = cur_q;
    idx_d = idx_q;
    if (clr) begin
      cur_d = '0;
      idx_d = '0;
    end else if (accept) begin
      cur_d = '0;
      idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
    end else if (inc) begin
      cur_d = cur_q + DIGIT_W'(1);  // natural wrap at 2**DIGIT_W
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= '0;
      idx_q <= '0;
    end else begin
      cur_q <= cur_d;
      idx_q <= idx_d;
    end
  end

  assign cur_digit = cur_q;
  assign digit_idx = idx_q;
endmodule

// File: rtl/lock_code_writer.sv
// Code-programming FSM: the new code is entered twice, compared, and only a
// matching pair is committed to the code driven to the lock.
module lock_code_writer
  import lock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               unlocked,
  input  logic               prog_req,
  input  logic               next_pulse,
  input  logic               enter_pulse,
  output logic [CODE_W-1:0]  code,
  output logic               busy,
  output logic [IDX_W-1:0]   digit_idx,
  output logic [DIGIT_W-1:0] cur_digit,
  output logic               done,
  output logic               err
);
  prog_state_e       state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d, buf1_q, buf1_d, buf2_q, buf2_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, done_d, err_q, err_d;
  logic              inc, accept, clr, last_digit;

  digit_entry u_entry (
    .clk        (clk),
    .rst        (rst),
    .inc        (inc),
    .accept     (accept),
    .clr        (clr),
    .cur_digit  (cur_digit),
    .digit_idx  (digit_idx),
    .last_digit (last_digit)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    buf1_d  = buf1_q;
    buf2_d  = buf2_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    inc     = 1'b0;
    accept  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (prog_req && unlocked) state_d = ST_FIRST;
      end
      ST_FIRST, ST_SECOND: begin
        // enter has priority; a coincident next is dropped
        inc    = next_pulse && !enter_pulse;
        accept = enter_pulse;
        if (enter_pulse) begin
          if (state_q == ST_FIRST) buf1_d = set_digit(buf1_q, digit_idx, cur_digit);
          else                     buf2_d = set_digit(buf2_q, digit_idx, cur_digit);
        end
        if (next_pulse || enter_pulse) begin
          cnt_d = '0;
          if (enter_pulse && last_digit)
            state_d = (state_q == ST_FIRST) ? ST_SECOND : ST_CHECK;
        end else if (tick) begin
          if (cnt_q == 8'(TIMEOUT_TICKS-1)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            clr     = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (buf1_q == buf2_q) begin
          code_d = buf1_q;
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= DEFAULT_CODE;
      buf1_q  <= '0;
      buf2_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      buf1_q  <= buf1_d;
      buf2_q  <= buf2_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign code = code_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_lock_code_writer.sv
// Directed bench for lock_code_writer: a per-cycle vector table for one full
// programming run, plus hand sequences for mismatch, wrap, timeout and reset.
module tb_lock_code_writer;
  logic        clk, rst, tick, unlocked, prog_req, next_pulse, enter_pulse;
  logic [15:0] code;
  logic        busy, done, err;
  logic [1:0]  digit_idx;
  logic [3:0]  cur_digit;

  int nchecks = 0;
  int nerrors = 0;

  lock_code_writer dut (
    .clk(clk), .rst(rst), .tick(tick), .unlocked(unlocked), .prog_req(prog_req),
    .next_pulse(next_pulse), .enter_pulse(enter_pulse), .code(code), .busy(busy),
    .digit_idx(digit_idx), .cur_digit(cur_digit), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        unl, prog, nxt, ent, tck;
    logic        busy;
    logic [1:0]  idx;
    logic [3:0]  cur;
    logic        done, err;
    logic [15:0] code;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, then sample 1ns after the edge
  task automatic cyc(input logic p, input logic n, input logic e, input logic t);
    prog_req = p; next_pulse = n; enter_pulse = e; tick = t;
    @(posedge clk); #1;
    prog_req = 1'b0; next_pulse = 1'b0; enter_pulse = 1'b0; tick = 1'b0;
  endtask

  task automatic enter_digit(input int v);
    for (int i = 0; i < v; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_row(input int i, input logic u, input logic p, input logic n,
                         input logic e, input logic b, input logic [1:0] x,
                         input logic [3:0] c, input logic d, input logic r,
                         input logic [15:0] k);
    tbl[i].unl = u; tbl[i].prog = p; tbl[i].nxt = n; tbl[i].ent = e; tbl[i].tck = 1'b0;
    tbl[i].busy = b; tbl[i].idx = x; tbl[i].cur = c; tbl[i].done = d; tbl[i].err = r;
    tbl[i].code = k;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; unlocked = 1'b0; prog_req = 1'b0;
    next_pulse = 1'b0; enter_pulse = 1'b0;

    // program 1,0,0,1 twice; unlocked drops mid-way and a stray prog_req is ignored
    set_row( 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row( 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0, 16'h1234);
    set_row( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row( 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row( 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row( 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'd1, 1'b0, 1'b0, 16'h1234);
    set_row( 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row( 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0, 16'h1234);
    set_row( 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row( 9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row(10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row(11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 4'd1, 1'b0, 1'b0, 16'h1234);
    set_row(12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 16'h1234);
    set_row(13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 16'h1001);
    set_row(14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 16'h1001);

    // 1: reset values
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_code", 32'(code), 32'h1234);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_idx",  32'(digit_idx), 32'd0);
    chk("rst_cur",  32'(cur_digit), 32'd0);

    // table run
    for (int i = 0; i < 15; i++) begin
      unlocked = tbl[i].unl;
      cyc(tbl[i].prog, tbl[i].nxt, tbl[i].ent, tbl[i].tck);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_idx",  i), 32'(digit_idx), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d_cur",  i), 32'(cur_digit), 32'(tbl[i].cur));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_err",  i), 32'(err),  32'(tbl[i].err));
      chk($sformatf("tbl%0d_code", i), 32'(code), 32'(tbl[i].code));
    end

    // 3: mismatch 5678 / 5679 keeps the default code
    do_reset();
    unlocked = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    enter_digit(5); enter_digit(6); enter_digit(7); enter_digit(8);
    enter_digit(5); enter_digit(6); enter_digit(7); enter_digit(9);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mis_err",  32'(err),  32'd1);
    chk("mis_done", 32'(done), 32'd0);
    chk("mis_code", 32'(code), 32'h1234);
    chk("mis_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mis_err_pulse", 32'(err), 32'd0);

    // 2: 5678 twice, done two edges after the final enter
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    enter_digit(5); enter_digit(6); enter_digit(7); enter_digit(8);
    enter_digit(5); enter_digit(6); enter_digit(7); enter_digit(8);
    chk("ok_done_early", 32'(done), 32'd0);
    chk("ok_code_early", 32'(code), 32'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ok_done", 32'(done), 32'd1);
    chk("ok_code", 32'(code), 32'h5678);
    chk("ok_busy", 32'(busy), 32'd0);

    // 4: 17 nexts wrap to 1; next+enter together stores the pre-increment 1
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("wrap_cur", 32'(cur_digit), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_idx", 32'(digit_idx), 32'd1);
    chk("both_cur", 32'(cur_digit), 32'd0);
    enter_digit(10); enter_digit(0); enter_digit(15);
    enter_digit(1); enter_digit(10); enter_digit(0); enter_digit(15);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("both_done", 32'(done), 32'd1);
    chk("both_code", 32'(code), 32'h1A0F);

    // 5: locked prog_req ignored; timeout after 64 idle ticks
    do_reset();
    unlocked = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("locked_busy", 32'(busy), 32'd0);
    unlocked = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_busy", 32'(busy), 32'd1);
    unlocked = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("to_pre_idx", 32'(digit_idx), 32'd1);
    for (int i = 0; i < 63; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("to_63_busy", 32'(busy), 32'd1);
    chk("to_63_err",  32'(err),  32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("to_err",  32'(err),  32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_idx",  32'(digit_idx), 32'd0);
    chk("to_cur",  32'(cur_digit), 32'd0);
    chk("to_code", 32'(code), 32'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_err_pulse", 32'(err), 32'd0);

    // 6: asynchronous reset during the second pass
    unlocked = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    enter_digit(1); enter_digit(1); enter_digit(1); enter_digit(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    enter_digit(1); enter_digit(1); enter_digit(1); enter_digit(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_ar_code", 32'(code), 32'h1111);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    enter_digit(2); enter_digit(2); enter_digit(2); enter_digit(2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_ar_busy", 32'(busy), 32'd1);
    chk("pre_ar_cur",  32'(cur_digit), 32'd1);
    rst = 1'b1;
    #2;
    chk("ar_code", 32'(code), 32'h1234);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_idx",  32'(digit_idx), 32'd0);
    chk("ar_cur",  32'(cur_digit), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_err",  32'(err),  32'd0);
    #2;
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_ar_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
